hdx_line_xcvr: RTL
==================

Name: hdx_line_xcvr

Overview:
Half-duplex single-wire serial endpoint built around one bidirectional pin. It drives the inout `line` only while transmitting a frame. At all other times it releases `line` to high-Z and samples it as a receiver. An external pull-up holds the idle line at 1. Two instances, one at each end of a wire, form a complete link; the block is the bidirectional counterpart of our one-way input-to-output path modules.

Parameters:
DATA_W, 8, payload bits per frame (1..16)
CLKS_PER_BIT, 4, clock cycles per bit period (even, >=4)
TURN_CYCLES, 2, cycles `line` stays released after a transmitted frame before receive is armed (>=1)

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
tx_data  input  DATA_W  payload to send, sampled on handshake
tx_valid  input  1  transmit request
tx_ready  output  1  block can accept tx_data this cycle
rx_data  output  DATA_W  last received payload
rx_valid  output  1  one-cycle pulse, rx_data updated
rx_err  output  1  one-cycle pulse with rx_valid when the frame is bad
drive_en  output  1  1 while the block drives `line`
line  inout  1  shared wire; driven with tx_bit when drive_en=1, else 1'bz

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low. While rst_n=0, on each edge: state=IDLE, drive_en=0 (line=z), tx_ready=0, rx_valid=0, rx_err=0, rx_data=0, sync flops=1.
- Synchronizer: `line` passes through 2 flops to give line_s. prev_s holds the previous line_s. Start detect = prev_s=1 && line_s=0.
- Frame format: start bit 0, then DATA_W data bits LSB-first, then stop bit 1. Each bit lasts CLKS_PER_BIT cycles.
- IDLE:
  - drive_en=0.
  - tx_ready = (state==IDLE) && line_s==1 && rst_n.
  - On tx_valid&&tx_ready, latch tx_data and go to TX. drive_en and start bit are registered, so they appear the cycle after the handshake edge.
  - Else, on start detect, go to RX.
  - Start detect wins over tx_valid in the same cycle, because tx_ready is already 0 then.
- TX:
  - Bit counter and cycle counter step through the frame. Total drive time = (DATA_W+2)*CLKS_PER_BIT cycles.
  - At the end of the stop bit: drive_en=0, go to TURN.
  - tx_valid is ignored during TX.
- TURN: line released; hold for TURN_CYCLES, then go to IDLE. Start detect is ignored in TURN.
- RX:
  - At CLKS_PER_BIT/2 cycles after entry, resample line_s. If it is 1, this is a false start: return to IDLE with no output.
  - Otherwise sample each data bit every CLKS_PER_BIT cycles, then sample the stop bit.
  - On the stop sample: rx_data<=shifted payload, rx_valid=1 for one cycle, rx_err=1 that same cycle if stop=0. Then go to IDLE.
  - A new frame needs a fresh 1->0 edge, so a stuck-low line does not retrigger.
- drive_en and the receive path are never active together. The block never drives `line` while in RX or TURN.
- Reset mid-operation: line is released on the reset edge. A partial frame produces no rx_valid.

Optional Feature:
Macro HDX_PARITY_EN.
- Defined:
  - Frame = start, data, even-parity bit, stop. Frame length is DATA_W+3 bit periods.
  - TX sends the XOR of tx_data.
  - RX sets rx_err if the parity check fails or the stop bit is 0.
- Undefined: no parity bit; rx_err reflects only the stop bit.

Test Plan:
1. CLKS_PER_BIT=4, DATA_W=8, send tx_data=0xA5 →
   - line = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
   - drive_en=1 for exactly 40 cycles, then z for 2 TURN cycles.
   - tx_ready=1 on the following cycle.
2. Bench drives a frame with 0x3C on the released line → one rx_valid pulse with rx_data=0x3C, rx_err=0; drive_en stays 0 throughout.
3. Bench drives 0x55 with stop bit 0 →
   - rx_valid=1, rx_err=1, rx_data=0x55.
   - Line held low afterwards gives no further rx_valid until it returns high and falls again.
4. Line low for 1 cycle only (glitch) → false start: no rx_valid, back to IDLE, tx_ready=1 after line_s returns high.
5. tx_valid=1 in the same cycle start detect fires →
   - tx_ready=0, the frame is received, tx is not accepted.
   - After the frame, tx handshake occurs and transmission proceeds.
6. rst_n=0 during data bit 3 of a TX →
   - Next edge: drive_en=0, line=z, tx_ready=0.
   - After rst_n=1: tx_ready=1 once line_s=1; no rx_valid was produced.

Source files
------------

// File: rtl/hdx_line_xcvr.sv
// Half-duplex single-wire serial endpoint: drives the line pin only while sending a frame, else
// receives. Define HDX_PARITY_EN to add an even-parity bit between the data and the stop bit.
module hdx_line_xcvr #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned TURN_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              drive_en,
  inout  wire               line
);

`ifdef HDX_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned NBITS = DATA_W + PAR_W + 2;
  localparam int unsigned CW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW    = $clog2(NBITS);
  localparam int unsigned TW    = $clog2(TURN_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StTx, StTurn, StRx} state_t;

  state_t            state;
  logic              sync1, line_s, prev_s;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [TW-1:0]     turn_cnt;
  logic [NBITS-1:0]  tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W:0]   rx_cat;
  logic              start_det, rx_tick;
`ifdef HDX_PARITY_EN
  logic              rx_par;
`endif

  assign line      = drive_en ? tx_sh[0] : 1'bz;
  assign tx_ready  = (state == StIdle) && line_s && rst_n;
  assign start_det = prev_s && !line_s;
  assign rx_cat    = {line_s, rx_sh};
  // Start bit is checked half a bit in; every later bit one full period after the previous sample.
  assign rx_tick   = (bit_cnt == '0) ? (cyc_cnt == CW'(CLKS_PER_BIT / 2 - 1))
                                     : (cyc_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= StIdle;
      drive_en <= 1'b0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      rx_data  <= '0;
      sync1    <= 1'b1;
      line_s   <= 1'b1;
      prev_s   <= 1'b1;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      turn_cnt <= '0;
      tx_sh    <= '1;
      rx_sh    <= '0;
`ifdef HDX_PARITY_EN
      rx_par   <= 1'b0;
`endif
    end else begin
      sync1    <= line;
      line_s   <= sync1;
      prev_s   <= line_s;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      unique case (state)
        StIdle: begin
          cyc_cnt <= '0;
          bit_cnt <= '0;
          if (tx_valid && tx_ready) begin
`ifdef HDX_PARITY_EN
            tx_sh <= {1'b1, ^tx_data, tx_data, 1'b0};
`else
            tx_sh <= {1'b1, tx_data, 1'b0};
`endif
            drive_en <= 1'b1;
            state    <= StTx;
          end else if (start_det) begin
`ifdef HDX_PARITY_EN
            rx_par <= 1'b0;
`endif
            state <= StRx;
          end
        end
        StTx: begin
          if (cyc_cnt == CW'(CLKS_PER_BIT - 1)) begin
            cyc_cnt <= '0;
            if (bit_cnt == BW'(NBITS - 1)) begin
              drive_en <= 1'b0;
              turn_cnt <= '0;
              state    <= StTurn;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx_sh   <= {1'b1, tx_sh[NBITS-1:1]};
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        StTurn: begin
          if (turn_cnt == TW'(TURN_CYCLES - 1)) state <= StIdle;
          else turn_cnt <= turn_cnt + TW'(1);
        end
        StRx: begin
          if (rx_tick) begin
            cyc_cnt <= '0;
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == '0) begin
              if (line_s) state <= StIdle;
            end else if (bit_cnt == BW'(NBITS - 1)) begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
`ifdef HDX_PARITY_EN
              rx_err   <= ~line_s | rx_par;
`else
              rx_err   <= ~line_s;
`endif
              state    <= StIdle;
            end else begin
`ifdef HDX_PARITY_EN
              rx_par <= rx_par ^ line_s;
`endif
              if (bit_cnt <= BW'(DATA_W)) rx_sh <= rx_cat[DATA_W:1];
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
